// File: rtl/spram_ctrl_pkg.sv
// Shared types and constants for the SPRAM initiator controller.
package spram_ctrl_pkg;

    localparam int CNT_W            = 16;
    localparam int ADDR_W           = 17;
    localparam int DATA_W           = 8;
    localparam int SLEEP_WAKE_EXTRA = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RD_WAIT,
        STBY,
        WAKE,
        SLEEP
    } state_e;

    // Clamp a cycle count into the counter range so large parameters saturate.
    function automatic logic [CNT_W-1:0] sat_cnt(input int unsigned v);
        if (v > ((32'd1 << CNT_W) - 32'd1))
            return '1;
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/spram_ctrl_if.sv
// Client-side request/response bus of the SPRAM controller.
interface spram_ctrl_if;
    import spram_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/spram_idle_timer.sv
// Shared saturating up/down counter for idle, wake and sleep timing.
// Priority: clear, then load, then count. done_o compares the current value.
module spram_idle_timer
    import spram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear/load/step, holding at the range limits.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/spram_ctrl.sv
// Initiator-side controller for the 128 KiB byte-addressed SPRAM wrapper.
// Optional sleep mode: define SPRAM_SLEEP_EN.
module spram_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES  = 64,
    parameter int unsigned WAKE_CYCLES  = 3,
    parameter int unsigned SLEEP_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    spram_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    output logic              mem_cs,
    output logic              mem_standby,
    output logic              mem_sleep,
    output logic              mem_poweroff_n,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [CNT_W-1:0] IDLE_TERM  = sat_cnt(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLEEP_TERM = sat_cnt(SLEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD  = sat_cnt(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_TERM  = CNT_W'(1);
`ifdef SPRAM_SLEEP_EN
    localparam logic [CNT_W-1:0] SLEEP_WAKE_LOAD = sat_cnt(WAKE_CYCLES + SLEEP_WAKE_EXTRA);
`endif

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_wren_q, mem_wren_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_standby_q, mem_standby_d;
    logic              mem_poweroff_n_q;
`ifdef SPRAM_SLEEP_EN
    logic              mem_sleep_q, mem_sleep_d;
`endif

    logic              tmr_clr, tmr_load, tmr_en, tmr_up, tmr_done;
    logic [CNT_W-1:0]  tmr_load_val, tmr_term;

    spram_idle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .up_i       (tmr_up),
        .term_i     (tmr_term),
        .done_o     (tmr_done)
    );

    // Next-state, registered-output and timer-control decode.
    always_comb begin
        state_d       = state_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_cs_d      = 1'b0;
        mem_wren_d    = 1'b0;
        mem_standby_d = mem_standby_q;
`ifdef SPRAM_SLEEP_EN
        mem_sleep_d   = mem_sleep_q;
`endif
        tmr_clr       = 1'b0;
        tmr_load      = 1'b0;
        tmr_load_val  = WAKE_LOAD;
        tmr_en        = 1'b0;
        tmr_up        = 1'b1;
        tmr_term      = IDLE_TERM;

        case (state_q)
            IDLE: begin
                // A request in the threshold cycle wins over entering standby.
                if (bus.req_valid) begin
                    mem_addr_d = bus.req_addr;
                    if (bus.req_we) mem_din_d = bus.req_wdata;
                    mem_cs_d   = 1'b1;
                    mem_wren_d = bus.req_we;
                    tmr_clr    = 1'b1;
                    state_d    = ACCESS;
                end else if (tmr_done) begin
                    mem_standby_d = 1'b1;
                    tmr_clr       = 1'b1;
                    state_d       = STBY;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ACCESS: begin
                // mem_addr is held so the wrapper lane mux still selects this byte.
                state_d = mem_wren_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                resp_rdata_d = mem_dout;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            STBY: begin
                tmr_term = SLEEP_TERM;
                if (bus.req_valid) begin
                    mem_standby_d = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_load_val  = WAKE_LOAD;
                    state_d       = WAKE;
                end
`ifdef SPRAM_SLEEP_EN
                else if (tmr_done) begin
                    mem_sleep_d = 1'b1;
                    tmr_clr     = 1'b1;
                    state_d     = SLEEP;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end
            WAKE: begin
                // Down-count from the loaded value; done marks the last wake cycle.
                tmr_up   = 1'b0;
                tmr_term = WAKE_TERM;
                tmr_en   = 1'b1;
                if (tmr_done) begin
                    tmr_clr = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef SPRAM_SLEEP_EN
            SLEEP: begin
                if (bus.req_valid) begin
                    mem_sleep_d   = 1'b0;
                    mem_standby_d = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_load_val  = SLEEP_WAKE_LOAD;
                    state_d       = WAKE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            mem_addr_q       <= '0;
            mem_din_q        <= '0;
            mem_wren_q       <= 1'b0;
            mem_cs_q         <= 1'b0;
            mem_standby_q    <= 1'b0;
            mem_poweroff_n_q <= 1'b1;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_addr_q       <= mem_addr_d;
            mem_din_q        <= mem_din_d;
            mem_wren_q       <= mem_wren_d;
            mem_cs_q         <= mem_cs_d;
            mem_standby_q    <= mem_standby_d;
            mem_poweroff_n_q <= 1'b1;
        end
    end

`ifdef SPRAM_SLEEP_EN
    // Sleep pin flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_sleep_q <= 1'b0;
        else     mem_sleep_q <= mem_sleep_d;
    end
    assign mem_sleep = mem_sleep_q;
`else
    assign mem_sleep = 1'b0;
`endif

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_wren       = mem_wren_q;
    assign mem_cs         = mem_cs_q;
    assign mem_standby    = mem_standby_q;
    assign mem_poweroff_n = mem_poweroff_n_q;

endmodule

// File: tb/tb_spram_ctrl.sv
// Self-checking bench for spram_ctrl with a behavioural SPRAM wrapper model
// (16-bit words, registered read word, combinational lane select on mem_addr[0]).
module tb_spram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wren, mem_cs, mem_standby, mem_sleep, mem_poweroff_n;
    logic [7:0]  mem_dout;

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int exp_resp = 0;
    int cs_run = 0;
    logic prev_rv = 1'b0;

    spram_ctrl_if bus_if();

    spram_ctrl #(.IDLE_CYCLES(64), .WAKE_CYCLES(3), .SLEEP_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_wren       (mem_wren),
        .mem_cs         (mem_cs),
        .mem_standby    (mem_standby),
        .mem_sleep      (mem_sleep),
        .mem_poweroff_n (mem_poweroff_n),
        .mem_dout       (mem_dout)
    );

    always #5 clk = ~clk;

    // Wrapper model
    logic [7:0]  mem_arr [0:131071];
    logic [15:0] word_q = '0;
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wren) mem_arr[mem_addr] <= mem_din;
            else word_q <= {mem_arr[{mem_addr[16:1], 1'b1}], mem_arr[{mem_addr[16:1], 1'b0}]};
        end
    end
    assign mem_dout = mem_addr[0] ? word_q[15:8] : word_q[7:0];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Protocol monitors
    always @(negedge clk) begin
        if (mem_cs) begin
            cs_run++;
            chk("cs_in_standby", {mem_standby, mem_sleep}, 2'b00);
        end else if (cs_run != 0) begin
            chk("cs_width", cs_run, 1);
            cs_run = 0;
        end
        if (mem_wren) chk("wren_without_cs", mem_cs, 1'b1);
        if (bus_if.resp_valid) begin
            resp_cnt++;
            chk("resp_single_cycle", prev_rv, 1'b0);
        end
        prev_rv = bus_if.resp_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Called on a negedge; returns on the first IDLE cycle after the access.
    task automatic do_req(input logic we, input logic [16:0] a, input logic [7:0] wd,
                          input logic [7:0] exp, input string nm);
        int t = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        while (!bus_if.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_ready"}, bus_if.req_ready, 1'b1);
        if (!bus_if.req_ready) begin
            bus_if.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk({nm, "_cs"}, mem_cs, 1'b1);
        chk({nm, "_wren"}, mem_wren, we);
        chk({nm, "_addr"}, mem_addr, a);
        if (we) chk({nm, "_din"}, mem_din, wd);
        @(negedge clk);
        if (!we) begin
            exp_resp++;
            chk({nm, "_rv_early"}, bus_if.resp_valid, 1'b0);
            chk({nm, "_cs_off"}, mem_cs, 1'b0);
            chk({nm, "_addr_held"}, mem_addr, a);
            @(negedge clk);
            chk({nm, "_rv"}, bus_if.resp_valid, 1'b1);
            chk({nm, "_rdata"}, bus_if.resp_rdata, exp);
        end
        chk({nm, "_ready_next"}, bus_if.req_ready, 1'b1);
    endtask

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1'b1, 17'h1A5A5, 8'h3C, 8'h00};
        vecs[1]  = '{1'b0, 17'h1A5A5, 8'h00, 8'h3C};
        vecs[2]  = '{1'b1, 17'h00000, 8'h11, 8'h00};
        vecs[3]  = '{1'b1, 17'h00001, 8'h22, 8'h00};
        vecs[4]  = '{1'b0, 17'h00000, 8'h00, 8'h11};
        vecs[5]  = '{1'b0, 17'h00001, 8'h00, 8'h22};
        vecs[6]  = '{1'b1, 17'h18000, 8'hAB, 8'h00};
        vecs[7]  = '{1'b1, 17'h18001, 8'hCD, 8'h00};
        vecs[8]  = '{1'b0, 17'h18000, 8'h00, 8'hAB};
        vecs[9]  = '{1'b0, 17'h18001, 8'h00, 8'hCD};
        vecs[10] = '{1'b0, 17'h00000, 8'h00, 8'h11};
        vecs[11] = '{1'b0, 17'h00001, 8'h00, 8'h22};
        vecs[12] = '{1'b1, 17'h1A5A4, 8'h77, 8'h00};
        vecs[13] = '{1'b0, 17'h1A5A5, 8'h00, 8'h3C};
        vecs[14] = '{1'b0, 17'h1A5A4, 8'h00, 8'h77};

        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", bus_if.req_ready, 1'b1);
        chk("rst_resp_valid", bus_if.resp_valid, 1'b0);
        chk("rst_rdata", bus_if.resp_rdata, 8'h00);
        chk("rst_mem_addr", mem_addr, 17'h0);
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_cs_wren", {mem_cs, mem_wren}, 2'b00);
        chk("rst_lowpower", {mem_standby, mem_sleep}, 2'b00);
        chk("rst_poweroff_n", mem_poweroff_n, 1'b1);
        rst = 1'b0;

        // Directed read/write table
        for (int i = 0; i < 15; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));

        // Standby after 64 idle cycles, then 3-cycle wake
        repeat (63) @(negedge clk);
        chk("idle64_standby", mem_standby, 1'b0);
        @(negedge clk);
        chk("idle65_standby", mem_standby, 1'b1);
        chk("idle65_ready", bus_if.req_ready, 1'b0);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 17'h1A5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("wake%0d_ready", i), bus_if.req_ready, 1'b0);
            chk($sformatf("wake%0d_standby", i), mem_standby, 1'b0);
        end
        @(negedge clk);
        chk("wake_done_ready", bus_if.req_ready, 1'b1);
        do_req(1'b0, 17'h1A5A5, 8'h00, 8'h3C, "post_wake_rd");

        // Request arrives in the threshold cycle
        repeat (63) @(negedge clk);
        do_req(1'b1, 17'h00002, 8'h5E, 8'h00, "collide_wr");
        chk("collide_standby", mem_standby, 1'b0);
        do_req(1'b0, 17'h00002, 8'h00, 8'h5E, "collide_rd");

        // Reset asserted while in RD_WAIT
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 17'h00001;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdwait_rst_cs", mem_cs, 1'b0);
        chk("rdwait_rst_rv", bus_if.resp_valid, 1'b0);
        chk("rdwait_rst_ready", bus_if.req_ready, 1'b1);
        chk("rdwait_rst_poweroff_n", mem_poweroff_n, 1'b1);
        chk("rdwait_rst_addr", mem_addr, 17'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_rv", i), bus_if.resp_valid, 1'b0);
            chk($sformatf("post_rst%0d_ready", i), bus_if.req_ready, 1'b1);
        end
        do_req(1'b0, 17'h00001, 8'h00, 8'h22, "post_rst_rd");

        // Long idle: standby, then sleep only when the feature is built
        repeat (63) @(negedge clk);
        chk("long_idle64_standby", mem_standby, 1'b0);
        repeat (16) @(negedge clk);
        chk("long_idle80_standby", mem_standby, 1'b1);
        chk("long_idle80_sleep", mem_sleep, 1'b0);
        @(negedge clk);
`ifdef SPRAM_SLEEP_EN
        chk("sleep_entered", {mem_sleep, mem_standby}, 2'b11);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 17'h1A5A5;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("swake%0d_ready", i), bus_if.req_ready, 1'b0);
            chk($sformatf("swake%0d_pins", i), {mem_sleep, mem_standby}, 2'b00);
        end
        @(negedge clk);
        chk("swake_done_ready", bus_if.req_ready, 1'b1);
        do_req(1'b0, 17'h1A5A5, 8'h00, 8'h3C, "post_sleep_rd");
`else
        chk("no_sleep_pin", {mem_sleep, mem_standby}, 2'b01);
        do_req(1'b0, 17'h1A5A5, 8'h00, 8'h3C, "post_stby_rd");
`endif

        repeat (3) @(negedge clk);
        chk("resp_count", resp_cnt, exp_resp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spram_ctrl.md
Name: spram_ctrl

Overview:
- Initiator-side controller for the 128 KiB byte-addressed SPRAM bank wrapper (17-bit byte address, 8-bit data, registered read data, combinational byte-lane select from the held address).
- Converts a valid/ready byte request stream from a client (CPU bus bridge, DMA) into correctly timed chip-select/write/address sequences.
- Captures read data into a one-cycle response.
- Manages SPRAM low-power pins: standby after idle, controlled wake-up.

Parameters:
IDLE_CYCLES, 64, consecutive idle cycles in IDLE before entering STBY; 1..65535
WAKE_CYCLES, 3, cycles standby is deasserted before the first access after STBY; 1..65535
SLEEP_CYCLES, 1024, further cycles in STBY before entering SLEEP (only with SPRAM_SLEEP_EN); 1..65535

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  client request valid
req_ready  out  1  request accepted when req_valid & req_ready at rising clk
req_addr  in  17  byte address
req_we  in  1  1 = write, 0 = read
req_wdata  in  8  write byte
resp_valid  out  1  one-cycle pulse, read data valid
resp_rdata  out  8  read byte, held until next read response
mem_addr  out  17  to wrapper addr
mem_din  out  8  to wrapper din
mem_wren  out  1  to wrapper wren
mem_cs  out  1  to wrapper cs
mem_standby  out  1  to wrapper standby
mem_sleep  out  1  to wrapper sleep
mem_poweroff_n  out  1  to wrapper poweroff_n; constant 1 (retention)
mem_dout  in  8  from wrapper dout

Behaviour:
- All mem_* outputs, req_ready, resp_valid and resp_rdata are registered.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; mem_addr=0; mem_din=0; mem_wren=0; mem_cs=0; mem_standby=0; mem_sleep=0; mem_poweroff_n=1; idle counter=0.
- States: IDLE, ACCESS, RD_WAIT, STBY, WAKE, SLEEP (SLEEP exists only with the macro). req_ready=1 only in IDLE.
- IDLE:
  - On accept (edge E0): latch the address into mem_addr, and the write byte into mem_din for writes. Next cycle: mem_cs=1, mem_wren=req_we. Go to ACCESS.
  - If no request: increment the idle counter.
  - When the counter reaches IDLE_CYCLES-1 with no request: go to STBY, mem_standby=1.
  - Request and threshold in the same cycle: the request wins and the counter clears.
- ACCESS (one cycle, memory samples at E1):
  - Next cycle: mem_cs=0, mem_wren=0.
  - Write: return to IDLE; the next request can be accepted at E2.
  - Read: go to RD_WAIT. mem_addr is held unchanged so the wrapper's lane/bank mux selects the correct byte.
- RD_WAIT: at E2, resp_rdata<=mem_dout and resp_valid=1 for exactly the cycle after E2; return to IDLE.
- Latency and throughput:
  - Read: resp_valid high in the cycle after the 2nd edge following acceptance.
  - Peak throughput: one write per 2 cycles, one read per 3 cycles.
- mem_addr changes only on acceptance. mem_cs and mem_wren are never high outside ACCESS.
- STBY: mem_standby=1. On req_valid: mem_standby<=0, load the wake counter, go to WAKE. The request is not accepted yet.
- WAKE: count WAKE_CYCLES, then go to IDLE with the counter cleared. The pending request is accepted there. req_valid dropping during WAKE still completes the wake.
- Client rule: the client must hold req_* stable while req_valid=1 and req_ready=0.
- Reset mid-operation: all outputs take reset values immediately. An in-flight read produces no response; an in-flight write may or may not have completed.
- Counters saturate and never wrap.

Optional Feature:
- SPRAM_SLEEP_EN defined:
  - STBY counts SLEEP_CYCLES idle cycles, then goes to SLEEP: mem_sleep=1, mem_standby=1.
  - On req_valid in SLEEP: mem_sleep<=0, mem_standby<=0, wake counter loaded with WAKE_CYCLES+4, go to WAKE.
- SPRAM_SLEEP_EN undefined: no SLEEP state; mem_sleep tied 0; the STBY sleep counter is not built.

Decomposition:
- Package spram_ctrl_pkg holds:
  - state enum (IDLE, ACCESS, RD_WAIT, STBY, WAKE, SLEEP);
  - localparam CNT_W=16;
  - address/data width constants 17/8;
  - SLEEP_WAKE_EXTRA=4.
- Sub-module spram_idle_timer: loadable, saturating down/up counter with clear, load, enable and done. Instantiated once and shared across idle, wake and sleep timing.

Test Plan:
- Write 0x1A5A5→0x3C, then read 0x1A5A5 → resp_valid exactly 2 edges after read accept; resp_rdata=0x3C; mem_cs high exactly 1 cycle per access.
- Write 0x00000=0x11 and 0x00001=0x22, read both back → 0x11 and 0x22. Repeat at 0x18000/0x18001 (bank 3 odd/even lanes) → no cross-bank or cross-lane aliasing.
- Idle 64 cycles → mem_standby=1 in cycle 65. Assert req_valid → standby drops, req_ready stays 0 for 3 cycles, then the request is accepted and the read data is correct.
- req_valid rises on the same cycle the idle count hits 63 → request accepted; mem_standby stays 0.
- Assert rst in RD_WAIT → resp_valid never pulses, mem_cs=0, mem_poweroff_n=1, req_ready=1 immediately after reset release.
- SPRAM_SLEEP_EN, SLEEP_CYCLES=16: idle 64+16 cycles → mem_sleep=1. Request → wake takes 7 cycles; read returns the pre-sleep value.
